series_adder_arbiter: RTL and testbench

SERIES_ADDER_ARBITER -- requirements
Module: series_adder_arbiter

---
 rtl/series_adder_arbiter.sv | 177 +++++++++++++++++
 tb/tb_series_adder_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/series_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : series_adder_arbiter
// Description : Round-robin arbiter granting N requesters access to a shared
//               M x 32-bit series adder streamer, with per-transaction timeout
//               and completion counting. All outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module series_adder_arbiter #(
    parameter int N       = 4,
    parameter int M       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_p,
    input  logic [N-1:0]           req_vld,
    input  logic [N*M*32-1:0]      req_data,
    output logic [N-1:0]           req_rdy,
    output logic [39:0]            rsp_data,
    output logic [N-1:0]           rsp_vld,
    output logic                   adder_data_vld,
    output logic [M*32-1:0]        adder_data_o,
    input  logic                   adder_data_rdy,
    input  logic [39:0]            adder_result_i,
    input  logic                   adder_result_vld,
    output logic                   busy,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic                   timeout_err,
    output logic [15:0]            done_cnt
);

    localparam int          c_IW  = $clog2(N);
    localparam int          c_DW  = M * 32;
    localparam logic [15:0] c_TO  = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [c_IW-1:0]     ptr_q, ptr_d;
    logic [N-1:0]        req_rdy_q, req_rdy_d;
    logic [N-1:0]        rsp_vld_q, rsp_vld_d;
    logic                adder_data_vld_q, adder_data_vld_d;
    logic [c_DW-1:0]     adder_data_q, adder_data_d;
    logic [39:0]         rsp_data_q, rsp_data_d;
    logic [c_IW-1:0]     grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                timeout_q, timeout_d;
    logic [15:0]         done_cnt_q, done_cnt_d;
    logic [15:0]         wait_cnt_q, wait_cnt_d;
    logic [15:0]         w_wait_inc;

    logic [c_DW-1:0]     w_slice [N];
    logic                w_found;
    logic [c_IW-1:0]     w_win;

    // Split the flat operand bus into one slice per requester.
    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_slice
            assign w_slice[g] = req_data[g*c_DW +: c_DW];
        end
    endgenerate

    // Round-robin pick: first asserted request scanning up from ptr+1, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int off = 1; off <= N; off++) begin
            logic [c_IW-1:0] idx;
            idx = c_IW'((int'(ptr_q) + off) % N);
            if (!w_found && req_vld[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    assign w_wait_inc = wait_cnt_q + 16'd1;

    // Next-state and registered-output computation for the IDLE/WAIT/DONE FSM.
    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        req_rdy_d        = '0;
        rsp_vld_d        = '0;
        adder_data_vld_d = 1'b0;
        adder_data_d     = adder_data_q;
        rsp_data_d       = rsp_data_q;
        grant_d          = grant_q;
        timeout_d        = timeout_q;
        done_cnt_d       = done_cnt_q;
        wait_cnt_d       = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                // Without streamer readiness requests simply stay pending.
                if (w_found && adder_data_rdy) begin
                    req_rdy_d[w_win] = 1'b1;
                    adder_data_vld_d = 1'b1;
                    adder_data_d     = w_slice[w_win];
                    grant_d          = w_win;
                    ptr_d            = w_win;
                    wait_cnt_d       = '0;
                    state_d          = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result arriving on the timeout cycle takes priority.
                if (adder_result_vld) begin
                    rsp_data_d         = adder_result_i;
                    rsp_vld_d[grant_q] = 1'b1;
                    done_cnt_d         = done_cnt_q + 16'd1;
                    state_d            = S_DONE;
                end else begin
                    wait_cnt_d = w_wait_inc;
                    if (w_wait_inc == c_TO) begin
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_q          <= S_IDLE;
            ptr_q            <= c_IW'(N - 1);
            req_rdy_q        <= '0;
            rsp_vld_q        <= '0;
            adder_data_vld_q <= 1'b0;
            adder_data_q     <= '0;
            rsp_data_q       <= '0;
            grant_q          <= '0;
            busy_q           <= 1'b0;
            timeout_q        <= 1'b0;
            done_cnt_q       <= '0;
            wait_cnt_q       <= '0;
        end else begin
            state_q          <= state_d;
            ptr_q            <= ptr_d;
            req_rdy_q        <= req_rdy_d;
            rsp_vld_q        <= rsp_vld_d;
            adder_data_vld_q <= adder_data_vld_d;
            adder_data_q     <= adder_data_d;
            rsp_data_q       <= rsp_data_d;
            grant_q          <= grant_d;
            busy_q           <= busy_d;
            timeout_q        <= timeout_d;
            done_cnt_q       <= done_cnt_d;
            wait_cnt_q       <= wait_cnt_d;
        end
    end

    assign req_rdy        = req_rdy_q;
    assign rsp_vld        = rsp_vld_q;
    assign adder_data_vld = adder_data_vld_q;
    assign adder_data_o   = adder_data_q;
    assign rsp_data       = rsp_data_q;
    assign grant_id       = grant_q;
    assign busy           = busy_q;
    assign timeout_err    = timeout_q;
    assign done_cnt       = done_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_series_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_series_adder_arbiter
// Description : Directed self-checking bench for series_adder_arbiter. Instance
//               a uses the default timeout, instance b uses TIMEOUT=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_series_adder_arbiter;

    localparam int c_N  = 4;
    localparam int c_M  = 8;
    localparam int c_DW = c_M * 32;

    logic                 clk;
    logic                 rst_p;
    logic [c_N-1:0]       req_vld;
    logic [c_N*c_DW-1:0]  req_data;
    logic                 adder_data_rdy;
    logic [39:0]          adder_result_i;
    logic                 res_vld_a, res_vld_b;

    logic [c_N-1:0]       req_rdy_a, rsp_vld_a, req_rdy_b, rsp_vld_b;
    logic [39:0]          rsp_data_a, rsp_data_b;
    logic                 adv_a, adv_b, busy_a, busy_b, to_a, to_b;
    logic [c_DW-1:0]      ado_a, ado_b;
    logic [1:0]           gid_a, gid_b;
    logic [15:0]          done_a, done_b;

    int n_checks = 0;
    int n_fail   = 0;

    series_adder_arbiter #(.N(c_N), .M(c_M)) u_dut_a (
        .clk(clk), .rst_p(rst_p), .req_vld(req_vld), .req_data(req_data),
        .req_rdy(req_rdy_a), .rsp_data(rsp_data_a), .rsp_vld(rsp_vld_a),
        .adder_data_vld(adv_a), .adder_data_o(ado_a),
        .adder_data_rdy(adder_data_rdy), .adder_result_i(adder_result_i),
        .adder_result_vld(res_vld_a), .busy(busy_a), .grant_id(gid_a),
        .timeout_err(to_a), .done_cnt(done_a)
    );

    series_adder_arbiter #(.N(c_N), .M(c_M), .TIMEOUT(16)) u_dut_b (
        .clk(clk), .rst_p(rst_p), .req_vld(req_vld), .req_data(req_data),
        .req_rdy(req_rdy_b), .rsp_data(rsp_data_b), .rsp_vld(rsp_vld_b),
        .adder_data_vld(adv_b), .adder_data_o(ado_b),
        .adder_data_rdy(adder_data_rdy), .adder_result_i(adder_result_i),
        .adder_result_vld(res_vld_b), .busy(busy_b), .grant_id(gid_b),
        .timeout_err(to_b), .done_cnt(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [c_DW-1:0] got, input logic [c_DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_p = 1'b1;
        tick();
        rst_p = 1'b0;
    endtask

    function automatic logic [c_DW-1:0] slice_val(input int i);
        logic [c_DW-1:0] v;
        for (int j = 0; j < c_M; j++) v[j*32 +: 32] = 32'hA000_0000 | (i << 8) | j;
        return v;
    endfunction

    initial begin
        logic [c_N-1:0] seen;
        logic [c_N-1:0] oh;

        rst_p = 1'b1; req_vld = '0; adder_data_rdy = 1'b0;
        adder_result_i = '0; res_vld_a = 1'b0; res_vld_b = 1'b0;
        for (int i = 0; i < c_N; i++) req_data[i*c_DW +: c_DW] = slice_val(i);

        // Reset values are present before any clock edge.
        #3;
        check("rst_req_rdy", c_DW'(req_rdy_a), 0);
        check("rst_rsp_vld", c_DW'(rsp_vld_a), 0);
        check("rst_busy", c_DW'(busy_a), 0);
        check("rst_adder_vld", c_DW'(adv_a), 0);
        check("rst_adder_data", ado_a, 0);
        check("rst_done_cnt", c_DW'(done_a), 0);
        check("rst_timeout", c_DW'(to_a), 0);
        tick();
        rst_p = 1'b0;

        // Single request from requester 1, result 40 cycles after issue.
        adder_data_rdy = 1'b1;
        req_vld = 4'b0010;
        tick();
        check("t1_req_rdy", c_DW'(req_rdy_a), 4'b0010);
        check("t1_adder_vld", c_DW'(adv_a), 1);
        check("t1_adder_data", ado_a, slice_val(1));
        check("t1_grant_id", c_DW'(gid_a), 1);
        req_vld = '0;
        tick();
        check("t1_req_rdy_pulse", c_DW'(req_rdy_a), 0);
        check("t1_adder_vld_pulse", c_DW'(adv_a), 0);
        check("t1_adder_data_hold", ado_a, slice_val(1));
        seen = '0;
        for (int k = 0; k < 38; k++) begin
            tick();
            seen = seen | rsp_vld_a | req_rdy_a;
        end
        check("t1_no_early_rsp", c_DW'(seen), 0);
        adder_result_i = 40'h12_3456_789A; res_vld_a = 1'b1;
        tick();
        res_vld_a = 1'b0;
        check("t1_rsp_vld", c_DW'(rsp_vld_a), 4'b0010);
        check("t1_rsp_data", c_DW'(rsp_data_a), 40'h12_3456_789A);
        check("t1_done_cnt", c_DW'(done_a), 1);
        check("t1_busy_done", c_DW'(busy_a), 1);
        tick();
        check("t1_rsp_vld_pulse", c_DW'(rsp_vld_a), 0);
        check("t1_busy_idle", c_DW'(busy_a), 0);

        // Round robin with all requesters held high.
        do_reset();
        req_vld = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            oh = 4'b0001 << (t % 4);
            tick();
            check("rr_grant_id", c_DW'(gid_a), t % 4);
            check("rr_req_rdy", c_DW'(req_rdy_a), oh);
            check("rr_adder_data", ado_a, slice_val(t % 4));
            adder_result_i = 40'h55_0000_0000 + 40'(t); res_vld_a = 1'b1;
            tick();
            res_vld_a = 1'b0;
            check("rr_rsp_vld", c_DW'(rsp_vld_a), oh);
            if (t == 4) req_vld = '0;
            tick();
            check("rr_no_grant_in_done", c_DW'(req_rdy_a), 0);
        end
        check("rr_done_cnt", c_DW'(done_a), 5);
        check("rr_rsp_data", c_DW'(rsp_data_a), 40'h55_0000_0004);

        // Streamer not ready: request stays pending, grant after ready rises.
        do_reset();
        adder_data_rdy = 1'b0;
        req_vld = 4'b0001;
        seen = '0;
        for (int k = 0; k < 20; k++) begin
            tick();
            seen = seen | req_rdy_a;
        end
        check("rg_no_grant", c_DW'(seen), 0);
        check("rg_idle", c_DW'(busy_a), 0);
        adder_data_rdy = 1'b1;
        tick();
        req_vld = '0;
        check("rg_grant", c_DW'(req_rdy_a), 4'b0001);

        // Timeout on instance b (TIMEOUT=16) with no response.
        do_reset();
        req_vld = 4'b0001;
        tick();
        req_vld = '0;
        check("to_grant", c_DW'(req_rdy_b), 4'b0001);
        for (int k = 0; k < 15; k++) tick();
        check("to_not_yet", c_DW'(to_b), 0);
        check("to_busy_wait", c_DW'(busy_b), 1);
        tick();
        check("to_err_set", c_DW'(to_b), 1);
        check("to_no_rsp", c_DW'(rsp_vld_b), 0);
        check("to_busy_done", c_DW'(busy_b), 1);
        tick();
        check("to_busy_idle", c_DW'(busy_b), 0);
        adder_result_i = 40'hDE_AD00_BEEF; res_vld_b = 1'b1;
        tick();
        res_vld_b = 1'b0;
        tick();
        check("to_late_rsp_vld", c_DW'(rsp_vld_b), 0);
        check("to_late_rsp_data", c_DW'(rsp_data_b), 0);
        check("to_late_done_cnt", c_DW'(done_b), 0);
        check("to_sticky", c_DW'(to_b), 1);

        // Result and timeout in the same cycle on instance b.
        do_reset();
        check("tie_rst_clears_err", c_DW'(to_b), 0);
        req_vld = 4'b0001;
        tick();
        req_vld = '0;
        for (int k = 0; k < 15; k++) tick();
        adder_result_i = 40'hAB_CDEF_0123; res_vld_b = 1'b1;
        tick();
        res_vld_b = 1'b0;
        check("tie_rsp_vld", c_DW'(rsp_vld_b), 4'b0001);
        check("tie_rsp_data", c_DW'(rsp_data_b), 40'hAB_CDEF_0123);
        check("tie_no_timeout", c_DW'(to_b), 0);
        check("tie_done_cnt", c_DW'(done_b), 1);

        // Reset five cycles into WAIT on instance a.
        do_reset();
        req_vld = 4'b0100;
        tick();
        req_vld = '0;
        check("rw_grant_id", c_DW'(gid_a), 2);
        for (int k = 0; k < 5; k++) tick();
        check("rw_busy_before", c_DW'(busy_a), 1);
        rst_p = 1'b1;
        #1;
        check("rw_busy", c_DW'(busy_a), 0);
        check("rw_grant_id_rst", c_DW'(gid_a), 0);
        check("rw_adder_data", ado_a, 0);
        check("rw_rsp_data", c_DW'(rsp_data_a), 0);
        tick();
        rst_p = 1'b0;
        adder_result_i = 40'h77_7777_7777; res_vld_a = 1'b1;
        tick();
        res_vld_a = 1'b0;
        check("rw_late_rsp_vld", c_DW'(rsp_vld_a), 0);
        check("rw_late_done_cnt", c_DW'(done_a), 0);
        req_vld = 4'b1001;
        tick();
        req_vld = '0;
        check("rw_next_grant", c_DW'(req_rdy_a), 4'b0001);
        check("rw_next_grant_id", c_DW'(gid_a), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
